cpu_run_monitor: RTL and testbench
==================================

CPU_RUN_MONITOR -- requirements
Module: cpu_run_monitor

Interface
REQ-001 Parameter XLEN, default 32, sets the width of the datapath, PC and instruction.
REQ-002 Parameter DEPTH, default 8, sets the number of trace FIFO entries and SHALL be a power of 2 and at least 2.
REQ-003 Parameter TIMEOUT, default 5000, is the run-cycle limit.
REQ-004 Parameter STALL_LIMIT, default 16, is the maximum number of consecutive cycles allowed without a retire.
REQ-005 Parameter HALT_INST, default 32'h00000073 (ecall), is the instruction that ends the run.
REQ-006 clk  input  1  is the single clock; all logic is on the rising edge.
REQ-007 reset  input  1  is a synchronous, active-low reset (0 = reset).
REQ-008 retire_valid  input  1  means one instruction retires this cycle.
REQ-009 retire_pc  input  XLEN  is the PC of the retiring instruction.
REQ-010 retire_inst  input  XLEN  is the encoding of the retiring instruction.
REQ-011 wb_en  input  1  is the register-file write enable.
REQ-012 wb_rd  input  5  is the register-file write index.
REQ-013 wb_data  input  XLEN  is the register-file write data.
REQ-014 trace_valid  output  1  means the FIFO head is valid.
REQ-015 trace_ready  input  1  means the consumer accepts the FIFO head.
REQ-016 trace_pc  output  XLEN  is the PC at the FIFO head.
REQ-017 trace_inst  output  XLEN  is the instruction at the FIFO head.
REQ-018 a10  output  XLEN  is a shadow copy of register x10.
REQ-019 cycle_count  output  32  counts run cycles.
REQ-020 retire_count  output  32  counts accepted retires.
REQ-021 done  output  1  means the run has ended and the trace is drained.
REQ-022 done_cause  output  2  reports why the run ended: 0 none, 1 ecall, 2 stall, 3 timeout.
REQ-023 overflow  output  1  is sticky and means a retire was dropped.

Function
REQ-024 The FSM SHALL have three states: RUN (reset state), DRAIN and DONE; every output SHALL be registered.
REQ-025 In RUN, a retire with retire_inst==HALT_INST SHALL be pushed to the FIFO, and the FSM SHALL move to DRAIN on the next edge with cause 1.
REQ-026 In RUN, when the idle counter (cycles since the last retire_valid, cleared by retire_valid) reaches STALL_LIMIT, the FSM SHALL move to DRAIN with cause 2.
REQ-027 In RUN, when cycle_count==TIMEOUT-1, the FSM SHALL move to DRAIN with cause 3.
REQ-028 If several halt conditions occur in the same cycle, the cause SHALL take priority ecall > stall > timeout.
REQ-029 In DRAIN, retires SHALL be ignored (not pushed, not counted); the FSM SHALL move to DONE in the cycle after the FIFO becomes empty.
REQ-030 DONE SHALL be sticky until reset; done=1 only in DONE; done_cause SHALL be latched on leaving RUN and held.
REQ-031 cycle_count SHALL increment in RUN and DRAIN, freeze in DONE, and saturate at 32'hFFFFFFFF.
REQ-032 retire_count SHALL increment on every retire_valid in RUN, including dropped ones.
REQ-033 A push occurs when retire_valid is high in RUN; a pop occurs when trace_valid and trace_ready are both high.
REQ-034 A push while full and without a pop SHALL be dropped and SHALL set overflow.
REQ-035 A push and a pop in the same cycle SHALL both take effect, full or not; the occupancy SHALL then be unchanged.
REQ-036 The FIFO SHALL be first-in first-out; trace_valid SHALL be 1 in the cycle after the first push into an empty FIFO (one-cycle latency).
REQ-037 trace_pc and trace_inst SHALL remain stable while trace_valid is high and trace_ready is low.
REQ-038 The FIFO read and write pointers SHALL wrap modulo DEPTH, with a separate occupancy count of 0..DEPTH.
REQ-039 a10 SHALL load wb_data when wb_en=1 and wb_rd==10, in any state; writes to any other index SHALL have no effect on a10.

Reset
REQ-040 When reset=0 at an edge, the next state SHALL be: FSM RUN; FIFO empty; trace_valid=0; trace_pc=0; trace_inst=0; a10=0; cycle_count=0; retire_count=0; idle counter=0; done=0; done_cause=0; overflow=0.
REQ-041 A reset applied mid-run or in DONE SHALL abort and discard all FIFO contents, with no partial pop; trace_ready is a don't-care while reset=0.

Verification
REQ-042 Scenario: 3 retires (pc 0,4,8), then HALT_INST at pc 12, with trace_ready=1 -> trace order 0,4,8,12; done_cause=1; retire_count=4; done=1 two cycles after the last pop.
REQ-043 Scenario: DEPTH=8, trace_ready=0, 10 consecutive retires -> 8 entries held; overflow=1; retire_count=10; release trace_ready -> the first 8 PCs pop in order.
REQ-044 Scenario: FIFO full, push and pop in the same cycle -> occupancy stays 8; overflow stays 0; the new entry appears last.
REQ-045 Scenario: no retire for 16 cycles after reset -> done_cause=2; done=1; cycle_count frozen.
REQ-046 Scenario: TIMEOUT=20, a retire every cycle with no ecall -> DRAIN entered at cycle_count=19; done_cause=3; cycle_count frozen once done=1.
REQ-047 Scenario: wb_en=1, wb_rd=10, wb_data=55, then wb_rd=11 with wb_data=7, then reset=0 -> a10=55, stays 55, then becomes 0.

Source files
------------

// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: watches a core's retire stream, keeps a small trace FIFO
// of retired (pc, inst) pairs, shadows x10 (a0), and decides when the run is
// over: ecall retired, too many cycles without a retire, or the overall
// cycle limit. After the run ends the trace drains, then DONE holds.
module cpu_run_monitor #(
  parameter int                XLEN        = 32,
  parameter int                DEPTH       = 8,     // power of 2, >= 2
  parameter int                TIMEOUT     = 5000,
  parameter int                STALL_LIMIT = 16,
  parameter logic [XLEN-1:0]   HALT_INST   = XLEN'(32'h00000073)
) (
  input  logic            clk,
  input  logic            reset,        // synchronous, active low
  input  logic            retire_valid,
  input  logic [XLEN-1:0] retire_pc,
  input  logic [XLEN-1:0] retire_inst,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            trace_valid,
  input  logic            trace_ready,
  output logic [XLEN-1:0] trace_pc,
  output logic [XLEN-1:0] trace_inst,
  output logic [XLEN-1:0] a10,
  output logic [31:0]     cycle_count,
  output logic [31:0]     retire_count,
  output logic            done,
  output logic [1:0]      done_cause,
  output logic            overflow
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(STALL_LIMIT + 1);

  localparam logic [1:0] CAUSE_ECALL   = 2'd1;
  localparam logic [1:0] CAUSE_STALL   = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } trace_t;

  state_t          state, state_nx;
  logic [1:0]      cause_nx;

  trace_t          mem [DEPTH];
  logic [AW-1:0]   wptr, rptr, rptr_nx;
  logic [CW-1:0]   count, count_nx;
  trace_t          head_nx;
  trace_t          wr_ent;

  logic [IW-1:0]   idle;

  logic            push, pop, full, wr, drop;
  logic            halt_hit, stall_hit, tmo_hit;

  // Handshake decode: retires only enter the trace while the run is live;
  // a pop is a plain valid/ready handshake on the registered head.
  always_comb begin
    push      = retire_valid && (state == RUN);
    pop       = trace_valid && trace_ready;
    full      = (count == CW'(DEPTH));
    wr        = push && (!full || pop);   // pop frees the slot in the same edge
    drop      = push && full && !pop;
    halt_hit  = push && (retire_inst == HALT_INST);
    stall_hit = (idle == IW'(STALL_LIMIT));
    tmo_hit   = (cycle_count == 32'(TIMEOUT - 1));
    wr_ent    = '{pc: retire_pc, inst: retire_inst};
  end

  // Next FIFO bookkeeping and the entry that will sit at the head next cycle.
  // When the FIFO is (or becomes, after this pop) empty, the head is the
  // entry being written right now, so bypass it straight to the outputs.
  always_comb begin
    rptr_nx  = pop ? rptr + AW'(1) : rptr;
    count_nx = count;
    case ({wr, pop})
      2'b10:   count_nx = count + CW'(1);
      2'b01:   count_nx = count - CW'(1);
      default: count_nx = count;
    endcase
    if (wr && (count == (pop ? CW'(1) : CW'(0))))
      head_nx = wr_ent;
    else
      head_nx = mem[rptr_nx];
  end

  // Trace storage; contents are don't-care until counted, so no reset here.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= wr_ent;
  end

  // FIFO pointers, occupancy and the registered head outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr        <= '0;
      rptr        <= '0;
      count       <= '0;
      trace_valid <= 1'b0;
      trace_pc    <= '0;
      trace_inst  <= '0;
    end else begin
      if (wr) wptr <= wptr + AW'(1);
      rptr        <= rptr_nx;
      count       <= count_nx;
      trace_valid <= (count_nx != '0);
      // Only move the head when something is there; holding it otherwise
      // keeps the outputs stable under back-pressure for free.
      if (count_nx != '0) begin
        trace_pc   <= head_nx.pc;
        trace_inst <= head_nx.inst;
      end
    end
  end

  // Run-control state register plus registered done/cause.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      done       <= 1'b0;
      done_cause <= 2'd0;
    end else begin
      state      <= state_nx;
      done       <= (state_nx == DONE);
      done_cause <= cause_nx;
    end
  end

  // Next state: halt conditions only matter while running, ecall wins over
  // stall which wins over timeout; drain waits for an empty trace.
  always_comb begin
    state_nx = state;
    cause_nx = done_cause;
    case (state)
      RUN: begin
        if (halt_hit) begin
          state_nx = DRAIN;
          cause_nx = CAUSE_ECALL;
        end else if (stall_hit) begin
          state_nx = DRAIN;
          cause_nx = CAUSE_STALL;
        end else if (tmo_hit) begin
          state_nx = DRAIN;
          cause_nx = CAUSE_TIMEOUT;
        end
      end
      DRAIN:   if (count == '0) state_nx = DONE;
      DONE:    state_nx = DONE;
      default: state_nx = RUN;
    endcase
  end

  // Run statistics: cycles (frozen once done, saturating), retires seen while
  // running (dropped ones included), idle gap since the last retire, and the
  // sticky overflow flag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count  <= '0;
      retire_count <= '0;
      idle         <= '0;
      overflow     <= 1'b0;
    end else begin
      if (state != DONE && cycle_count != '1)
        cycle_count <= cycle_count + 32'd1;
      if (push)
        retire_count <= retire_count + 32'd1;
      if (state == RUN) begin
        if (retire_valid)
          idle <= '0;
        else if (idle != IW'(STALL_LIMIT))
          idle <= idle + IW'(1);
      end
      if (drop)
        overflow <= 1'b1;
    end
  end

  // Shadow of a0 (x10); tracks writeback in every state so the final
  // return value is visible after the run ends.
  always_ff @(posedge clk) begin
    if (!reset)
      a10 <= '0;
    else if (wb_en && wb_rd == 5'd10)
      a10 <= wb_data;
  end

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Bench for cpu_run_monitor: directed run scenarios plus randomized traffic,
// all compared each cycle against a queue-based behavioural model.
module tb_cpu_run_monitor;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 8;
  localparam int          TO    = 20;
  localparam int          SL    = 16;
  localparam logic [31:0] HALT  = 32'h00000073;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic            clk = 1'b0;
  logic            reset;
  logic            retire_valid;
  logic [XLEN-1:0] retire_pc, retire_inst;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            trace_valid, trace_ready;
  logic [XLEN-1:0] trace_pc, trace_inst, a10;
  logic [31:0]     cycle_count, retire_count;
  logic            done, overflow;
  logic [1:0]      done_cause;

  always #5 clk = ~clk;

  cpu_run_monitor #(
    .XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(TO), .STALL_LIMIT(SL), .HALT_INST(HALT)
  ) dut (
    .clk(clk), .reset(reset),
    .retire_valid(retire_valid), .retire_pc(retire_pc), .retire_inst(retire_inst),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .trace_pc(trace_pc), .trace_inst(trace_inst),
    .a10(a10), .cycle_count(cycle_count), .retire_count(retire_count),
    .done(done), .done_cause(done_cause), .overflow(overflow)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
  ent_t        mq[$];
  bit          m_run, m_drain, m_done, m_ovf;
  int          m_idle;
  logic [31:0] m_cyc, m_rcnt, m_a10;
  logic [1:0]  m_cause;

  logic [31:0] popped[$];
  int          obs_idx = 0;

  // Advance the model across one rising edge using the inputs now driven.
  function automatic void model_edge();
    int sz;
    bit push, pop, halt_e, stall, tmo;
    ent_t e;
    if (!reset) begin
      mq.delete();
      m_run = 1; m_drain = 0; m_done = 0; m_ovf = 0;
      m_idle = 0; m_cyc = 0; m_rcnt = 0; m_a10 = 0; m_cause = 0;
      return;
    end
    sz     = mq.size();
    push   = retire_valid && m_run;
    pop    = (sz > 0) && trace_ready;
    halt_e = push && (retire_inst == HALT);
    stall  = m_run && (m_idle >= SL);
    tmo    = m_run && (m_cyc == 32'(TO - 1));
    if (wb_en && wb_rd == 5'd10) m_a10 = wb_data;
    if (!m_done && m_cyc != 32'hFFFFFFFF) m_cyc = m_cyc + 1;
    if (m_run) m_idle = retire_valid ? 0 : ((m_idle < SL) ? m_idle + 1 : m_idle);
    if (push) m_rcnt = m_rcnt + 1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) begin
        e.pc = retire_pc; e.inst = retire_inst;
        mq.push_back(e);
      end else m_ovf = 1;
    end
    if (m_run && (halt_e || stall || tmo)) begin
      m_cause = halt_e ? 2'd1 : (stall ? 2'd2 : 2'd3);
      m_run = 0; m_drain = 1;
    end else if (m_drain && sz == 0) begin
      m_drain = 0; m_done = 1;
    end
  endfunction

  task automatic check_outputs();
    chk("trace_valid", trace_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk("trace_pc", trace_pc, mq[0].pc);
      chk("trace_inst", trace_inst, mq[0].inst);
    end
    chk("a10", a10, m_a10);
    chk("cycle_count", cycle_count, m_cyc);
    chk("retire_count", retire_count, m_rcnt);
    chk("done", done, m_done);
    chk("done_cause", done_cause, m_cause);
    chk("overflow", overflow, m_ovf);
  endtask

  // One clock: log a handshake about to happen, model the edge, compare.
  task automatic step();
    if (reset && trace_valid && trace_ready) popped.push_back(trace_pc);
    model_edge();
    @(negedge clk);
    check_outputs();
    obs_idx++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; retire_valid = 1'b0; wb_en = 1'b0;
    trace_ready = 1'($urandom);     // must not matter during reset
    repeat (n) step();
    reset = 1'b1; trace_ready = 1'b0;
    popped.delete();
  endtask

  task automatic run_to_done(input string tag, input int max);
    int n = 0;
    while (!done && n < max) begin step(); n++; end
    if (!done) chk({tag, "_done_timeout"}, done, 1);
  endtask

  logic [31:0] frozen;
  int          last_pop;

  initial begin
    reset = 1'b0; retire_valid = 1'b0; retire_pc = '0; retire_inst = '0;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0; trace_ready = 1'b0;

    // reset state
    do_reset(2);
    chk("rst_valid", trace_valid, 0);
    chk("rst_cyc", cycle_count, 0);
    chk("rst_done", done, 0);

    // ecall after three retires, consumer always ready
    trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      retire_valid = 1'b1; retire_pc = 32'(4 * i); retire_inst = NOP; step();
    end
    retire_pc = 32'd12; retire_inst = HALT; step();
    retire_valid = 1'b0;
    last_pop = -1;
    for (int n = 0; n < 20 && !done; n++) begin
      if (trace_valid && trace_ready) last_pop = obs_idx;
      step();
    end
    chk("ecall_done", done, 1);
    chk("ecall_lat", 32'(obs_idx - last_pop), 2);
    chk("ecall_cause", done_cause, 1);
    chk("ecall_rcnt", retire_count, 4);
    chk("ecall_npop", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("ecall_order", popped[i], 32'(4 * i));

    // overflow: ten retires into a stalled consumer
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      retire_valid = 1'b1; retire_pc = 32'h100 + 32'(4 * i); retire_inst = NOP; step();
    end
    retire_valid = 1'b0;
    chk("ovf_flag", overflow, 1);
    chk("ovf_rcnt", retire_count, 10);
    trace_ready = 1'b1;
    run_to_done("ovf", 40);
    chk("ovf_npop", popped.size(), 8);
    for (int i = 0; i < 8 && i < popped.size(); i++) chk("ovf_order", popped[i], 32'h100 + 32'(4 * i));

    // push and pop together while full
    do_reset(1);
    for (int i = 0; i < 8; i++) begin
      retire_valid = 1'b1; retire_pc = 32'h200 + 32'(4 * i); retire_inst = NOP; step();
    end
    retire_pc = 32'h2F0; trace_ready = 1'b1; step();
    retire_valid = 1'b0;
    chk("full_ovf", overflow, 0);
    run_to_done("full", 40);
    chk("full_npop", popped.size(), 9);
    if (popped.size() == 9) begin
      chk("full_first", popped[0], 32'h200);
      chk("full_last", popped[8], 32'h2F0);
    end

    // stall: nothing retires after reset
    do_reset(1);
    run_to_done("stall", 40);
    chk("stall_cause", done_cause, 2);
    chk("stall_cyc", cycle_count, 18);
    frozen = cycle_count;
    repeat (3) step();
    chk("stall_frozen", cycle_count, frozen);

    // timeout: retire every cycle, never an ecall
    do_reset(1);
    trace_ready = 1'b1; retire_valid = 1'b1; retire_inst = NOP;
    for (int n = 0; n < 40 && !done; n++) begin
      retire_pc = 32'h400 + 32'(4 * n); step();
    end
    chk("tmo_done", done, 1);
    chk("tmo_cause", done_cause, 3);
    chk("tmo_rcnt", retire_count, 20);
    chk("tmo_cyc", cycle_count, 22);
    frozen = cycle_count;
    repeat (3) step();
    chk("tmo_frozen", cycle_count, frozen);
    retire_valid = 1'b0;

    // a10 shadow
    do_reset(1);
    wb_en = 1'b1; wb_rd = 5'd10; wb_data = 32'd55; step();
    chk("a10_load", a10, 55);
    wb_rd = 5'd11; wb_data = 32'd7; step();
    chk("a10_hold", a10, 55);
    wb_en = 1'b0; reset = 1'b0; step();
    chk("a10_reset", a10, 0);
    reset = 1'b1;

    // randomized runs, occasional mid-run resets
    for (int run = 0; run < 15; run++) begin
      do_reset(1 + int'($urandom_range(1, 0)));
      for (int c = 0; c < 40; c++) begin
        reset        = ($urandom_range(49, 0) != 0);
        retire_valid = (run % 3 == 2) ? ($urandom_range(7, 0) == 0) : ($urandom_range(3, 0) != 0);
        retire_pc    = $urandom;
        retire_inst  = ($urandom_range(15, 0) == 0) ? HALT : $urandom;
        trace_ready  = 1'($urandom);
        wb_en        = 1'($urandom);
        wb_rd        = ($urandom_range(2, 0) == 0) ? 5'd10 : 5'($urandom);
        wb_data      = $urandom;
        step();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
